// File: rtl/bit_serializer.sv
// bit_serializer: LSB-first parallel-to-serial converter with a one-word hold buffer.
// Define SER_PARITY_EN to append one even-parity bit after every word.
module bit_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             w_accept;
  logic             w_data_end;
  logic             w_last;
  logic [WIDTH-1:0] w_next;
  assign din_ready  = !r_hold_full && !rst;
  assign w_accept   = din_valid && din_ready;
  assign w_data_end = r_state == SHIFT && r_cnt == CW'(WIDTH-1);
  assign w_next     = r_hold_full ? r_hold : din;
  assign ser_valid  = r_state != IDLE;
  assign busy       = ser_valid || r_hold_full;
  assign ser_last   = w_last;
`ifdef SER_PARITY_EN
  logic r_par;
  assign w_last  = r_state == PARITY;
  assign ser_out = w_last ? r_par : (r_state == SHIFT) && r_shift[0];
`else
  assign w_last  = w_data_end;
  assign ser_out = ser_valid && r_shift[0];
`endif
  // Word boundaries (idle or terminal edge) pick the next word: held word first, else a bypassed offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
`ifdef SER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else if (r_state == IDLE || w_last) begin
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
      if (r_hold_full || w_accept) begin
        r_state <= SHIFT;
        r_shift <= w_next;
`ifdef SER_PARITY_EN
        r_par   <= ^w_next;
`endif
      end else
        r_state <= IDLE;
    end else begin
      if (w_accept) begin
        r_hold      <= din;
        r_hold_full <= 1'b1;
      end
`ifdef SER_PARITY_EN
      if (w_data_end)
        r_state <= PARITY;
      else
`endif
      begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed and randomized checks of bit_serializer (WIDTH 16 and 4)
// against a bit-queue reference model of the expected serial stream.
module tb_bit_serializer;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W0 = 16;
  localparam int W1 = 4;
  typedef struct packed {logic b; logic last;} sbit_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dv = '0;
  logic [15:0] dn0 = '0;
  logic [3:0]  dn1 = '0;
  logic [1:0]  rdy, so, sv, sl, bz;
  sbit_t       mq [2][256];
  int          head [2], tail [2], nw [2], acc_cnt [2], last_acc [2], run [2], last_run [2];
  logic [63:0] obs [2];
  int          cyc = 0, total = 0, passes = 0;
  logic [15:0] mw;
  int          mwd;
  logic        ne;
  sbit_t       fb;
  logic [4:0]  me, ma;

  bit_serializer #(.WIDTH(W0)) u0 (.clk(clk), .rst(rst), .din(dn0), .din_valid(dv[0]), .din_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0]));
  bit_serializer #(.WIDTH(W1)) u1 (.clk(clk), .rst(rst), .din(dn1), .din_valid(dv[1]), .din_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1]));

  always #5 clk = ~clk;

  // Every accepted word appends its LSB-first bits (plus parity) to the expected stream.
  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      mwd = u ? W1 : W0;
      mw = u ? {12'b0, dn1} : dn0;
      if (rst) begin
        head[u] = tail[u];
        nw[u] = 0;
      end else if (dv[u] && rdy[u]) begin
        for (int i = 0; i < mwd; i++) begin
          mq[u][tail[u] % 256] = {mw[i], PAR == 0 && i == mwd - 1};
          tail[u]++;
        end
        if (PAR != 0) begin
          mq[u][tail[u] % 256] = {1'($countones(mw) % 2), 1'b1};
          tail[u]++;
        end
        nw[u]++;
        acc_cnt[u]++;
        last_acc[u] = cyc;
      end
    end
  end

  // A pending stream means valid every cycle with no gaps; two pending words means the hold buffer is full.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ne = head[u] != tail[u];
      fb = mq[u][head[u] % 256];
      me = {ne, ne & fb.b, ne & fb.last, ne, !rst && nw[u] < 2};
      ma = {sv[u], so[u], sl[u], bz[u], rdy[u]};
      total++;
      if (ma !== me)
        $display("FAIL stream u%0d cycle %0d: {valid,out,last,busy,ready} got %b required %b", u, cyc, ma, me);
      else
        passes++;
      if (ne) begin
        if (fb.last) nw[u]--;
        head[u]++;
      end
      if (sv[u] === 1'b1) begin
        if (run[u] == 0) obs[u] = '0;
        if (run[u] < 64) obs[u][run[u]] = so[u];
        run[u]++;
      end else if (run[u] != 0) begin
        last_run[u] = run[u];
        run[u] = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input int u, input logic [15:0] w);
    int c0, n;
    c0 = acc_cnt[u];
    n = 0;
    if (u == 0) dn0 = w; else dn1 = w[3:0];
    dv[u] = 1'b1;
    do begin
      step(1);
      n++;
    end while (acc_cnt[u] == c0 && n < 300);
    total++;
    if (acc_cnt[u] == c0) $display("FAIL accept u%0d: word %h not taken after %0d cycles, required acceptance", u, w, n);
    else passes++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    dv = '0;
    while ((bz !== 2'b00 || head[0] != tail[0] || head[1] != tail[1]) && n < 400) begin
      step(1);
      n++;
    end
    total++;
    if (n >= 400) $display("FAIL idle timeout: busy=%b after %0d cycles, required 00", bz, n);
    else passes++;
  endtask

  task automatic test_reset();
    step(2);
    total++;
    if ({sv, so, sl, bz, rdy} !== 10'b0) $display("FAIL reset outputs: got %b required 0", {sv, so, sl, bz, rdy});
    else passes++;
    rst = 1'b0;
    #1;
    total++;
    if (rdy !== 2'b11) $display("FAIL reset ready release: got %b required 11", rdy);
    else passes++;
    step(1);
  endtask

  task automatic test_single();
    send(0, 16'h5772);
    wait_idle();
    total++;
    if (last_run[0] !== 16 + PAR) $display("FAIL single length: got %0d required %0d", last_run[0], 16 + PAR);
    else passes++;
    total++;
    if (obs[0][16:0] !== (PAR ? 17'h15772 : 17'h05772)) $display("FAIL single bits: got %h required %h", obs[0][16:0], PAR ? 17'h15772 : 17'h05772);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [33:0] e;
    e = PAR ? {1'b0, 16'hFFFF, 1'b1, 16'h5772} : {2'b0, 16'hFFFF, 16'h5772};
    send(0, 16'h5772);
    t0 = last_acc[0];
    dv[0] = 1'b0;
    step(3);
    send(0, 16'hFFFF);
    total++;
    if (last_acc[0] - t0 !== 4) $display("FAIL b2b offer timing: got %0d required 4", last_acc[0] - t0);
    else passes++;
    wait_idle();
    total++;
    if (last_run[0] !== 32 + 2 * PAR) $display("FAIL b2b length: got %0d required %0d", last_run[0], 32 + 2 * PAR);
    else passes++;
    total++;
    if (obs[0][33:0] !== e) $display("FAIL b2b bits: got %h required %h", obs[0][33:0], e);
    else passes++;
  endtask

  task automatic test_three();
    logic [15:0] a, b, c;
    int ta;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    send(0, a);
    ta = last_acc[0];
    send(0, b);
    total++;
    if (rdy[0] !== 1'b0) $display("FAIL three stall: ready got %b required 0", rdy[0]);
    else passes++;
    send(0, c);
    total++;
    if (last_acc[0] - ta !== W0 + 1 + PAR) $display("FAIL three third accept: got %0d required %0d", last_acc[0] - ta, W0 + 1 + PAR);
    else passes++;
    wait_idle();
    total++;
    if (last_run[0] !== 3 * (16 + PAR)) $display("FAIL three length: got %0d required %0d", last_run[0], 3 * (16 + PAR));
    else passes++;
    total++;
    if ({obs[0][32 + 2 * PAR +: 16], obs[0][16 + PAR +: 16], obs[0][15:0]} !== {c, b, a})
      $display("FAIL three bits: got %h required %h", {obs[0][32 + 2 * PAR +: 16], obs[0][16 + PAR +: 16], obs[0][15:0]}, {c, b, a});
    else passes++;
  endtask

  task automatic test_reset_mid();
    send(0, 16'h5772);
    dv[0] = 1'b0;
    step(5);
    rst = 1'b1;
    step(1);
    total++;
    if ({sv[0], bz[0], rdy[0]} !== 3'b000) $display("FAIL midreset outputs: {valid,busy,ready} got %b required 000", {sv[0], bz[0], rdy[0]});
    else passes++;
    total++;
    if (last_run[0] !== 6) $display("FAIL midreset partial length: got %0d required 6", last_run[0]);
    else passes++;
    rst = 1'b0;
    #1;
    total++;
    if (rdy[0] !== 1'b1) $display("FAIL midreset ready: got %b required 1", rdy[0]);
    else passes++;
    send(0, 16'h00F1);
    wait_idle();
    total++;
    if (last_run[0] !== 16 + PAR || obs[0][15:0] !== 16'h00F1) $display("FAIL midreset restart: len %0d bits %h required %0d %h", last_run[0], obs[0][15:0], 16 + PAR, 16'h00F1);
    else passes++;
  endtask

  task automatic test_bypass();
    logic [3:0] a;
    int ta;
    a = 4'($urandom);
    send(1, {12'b0, a});
    ta = last_acc[1];
    dv[1] = 1'b0;
    step(3 + PAR);
    send(1, 16'h0009);
    total++;
    if (last_acc[1] - ta !== W1 + PAR) $display("FAIL bypass timing: got %0d required %0d", last_acc[1] - ta, W1 + PAR);
    else passes++;
    wait_idle();
    total++;
    if (last_run[1] !== 8 + 2 * PAR) $display("FAIL bypass length: got %0d required %0d", last_run[1], 8 + 2 * PAR);
    else passes++;
    total++;
    if ({obs[1][4 + PAR +: 4], obs[1][3:0]} !== {4'b1001, a}) $display("FAIL bypass bits: got %b required %b", {obs[1][4 + PAR +: 4], obs[1][3:0]}, {4'b1001, a});
    else passes++;
  endtask

  task automatic test_random();
    int u;
    for (int i = 0; i < 40; i++) begin
      u = int'($urandom_range(0, 1));
      send(u, 16'($urandom));
      if ($urandom_range(0, 1) == 0) dv[u] = 1'b0;
      step(int'($urandom_range(0, 12)));
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_three();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
